divideby_n_fsm: RTL and testbench
=================================

# divideby_n_fsm

Parametrised successor to the fixed divide-by-3 Moore FSM: a programmable divide-by-N sequence generator with a runtime-loadable divisor, pulse or square-wave output mode, and an enable gate. It sits in the clocking/timing utilities as a clock-enable and strobe source for downstream sequential blocks. Divisor and mode changes are glitch-free: they take effect only at a period boundary.

## Interface
- `WIDTH`, 8: width of divisor and counter; legal divisors are 1..2^WIDTH-1.
- `DEFAULT_DIV`, 3: divisor after reset, in 1..2^WIDTH-1.
- `clk`  input  1  sole clock; all state updates on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `en`  input  1  count enable; when low, all state holds.
- `load`  input  1  one-cycle request to load `div_in`/`mode_in`.
- `div_in`  input  WIDTH  requested divisor.
- `mode_in`  input  1  requested mode: 0 is pulse, 1 is square.
- `y`  output  1  divided output, decoded from registered state only.
- `tick`  output  1  registered one-cycle period-boundary strobe.
- `err`  output  1  registered one-cycle pulse when a load is rejected.
- `pending`  output  1  a loaded value is waiting for the next boundary.
- `div_o`  output  WIDTH  divisor currently in effect.

## Operation
- Registers:
  - `cnt` (WIDTH): counts 0..`div_q`-1.
  - `div_q`, `mode_q`: active settings.
  - `div_p`, `mode_p`, `pend_q`: pending settings and their valid flag.
  - `tick_q`, `err_q`.
- Reset values: `cnt`=0, `div_q`=`DEFAULT_DIV`, `mode_q`=0, `pend_q`=0, `tick_q`=0, `err_q`=0.
- Outputs out of reset: `y`=1, `tick`=0, `err`=0, `pending`=0, `div_o`=`DEFAULT_DIV`.
- Counting, with `en`=1 and no reset:
  - If `cnt`==`div_q`-1, `cnt` wraps to 0. This is the boundary.
  - Otherwise `cnt` increments.
- With `en`=0: `cnt` holds, so `y` holds; `tick` is 0 next cycle; loads are still accepted into the pending registers.
- `y` decode:
  - Pulse mode: `y` = (`cnt`==0).
  - Square mode: `y` = (`cnt` < H), where H = (`div_q`+1)>>1, computed in WIDTH+1 bits to avoid overflow.
  - An odd N gives a high phase one cycle longer than the low phase.
- `tick_q` <= `en` && boundary. `tick` is therefore high exactly in the cycle where `cnt` has just wrapped to 0. It is never high in the first cycle after reset.
- Load handling:
  - `load` with `div_in`==0: rejected. `err_q` pulses next cycle; active and pending state are unchanged.
  - `load` with `div_in`>=1 and no boundary in the same cycle: `div_p`/`mode_p` are captured and `pend_q` is set. A later load overwrites the pending value (last wins).
  - `load` coinciding with a boundary: the new value bypasses the pending registers and becomes `div_q`/`mode_q` at that same wrap. `pend_q` is cleared.
  - At a boundary with `pend_q`=1 and no coinciding load: `div_q`/`mode_q` take the pending values and `pend_q` is cleared.
- N=1: the boundary occurs every enabled cycle, `cnt` stays 0, `y`=1 continuously in both modes, and `tick`=1 every enabled cycle after the first.
- N=2^WIDTH-1 in square mode: H=2^(WIDTH-1). There is no overflow.
- A reset asserted mid-period overrides everything, including a coinciding `load`. It discards the pending value; all registers take their reset values at that edge.

## Timing
- Divisor N in effect gives a `y` period of exactly N enabled cycles.
- Cycles with `en`=0 stretch the period and do not count.
- Load-to-effect latency: takes effect at the first boundary edge at or after the `load` edge. `div_o` updates on that edge.
- `err` is high in the cycle after the rejected `load` edge, for one cycle.
- `pending` rises in the cycle after an accepted non-boundary load. It falls on the applying boundary.
- `y` has no combinational path from any input. It depends only on `cnt`, `div_q` and `mode_q`.

## Test plan
- Reset, then `en`=1 for 9 cycles:
  - `y` = 1,0,0,1,0,0,1,0,0.
  - `tick` high in cycles 3 and 6 only.
  - `div_o`=3.
- Load `div_in`=5, `mode_in`=1 at `cnt`=1:
  - `pending`=1 until the wrap.
  - Then `y` = 1,1,1,0,0 repeating and `div_o`=5.
- Load `div_in`=0:
  - `err` pulses once one cycle later.
  - `pending`, `div_o` and the `y` pattern are unchanged.
- Two loads in one period (4, then 2):
  - Only 2 applies at the boundary; no period of 4 ever appears.
  - A load coinciding with the wrap applies immediately.
- `en` low for 4 cycles mid-period with N=3:
  - `y` and `cnt` hold.
  - `tick` stays 0.
  - The period resumes where it stopped.
- `WIDTH`=8: load 255 in square mode → `y` high 128 cycles, low 127. Then assert `reset` mid-period together with a `load` → `div_o`=3, `pending`=0, `y`=1 on the next cycle.

Source files
------------

// File: rtl/divideby_n_fsm.sv
// Programmable divide-by-N sequence generator with pulse/square output,
// runtime-loadable divisor applied only at period boundaries, and count enable.
module divideby_n_fsm #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  input  logic             mode_in,
  output logic             y,
  output logic             tick,
  output logic             err,
  output logic             pending,
  output logic [WIDTH-1:0] div_o
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH:0]   ONE_X   = (WIDTH+1)'(1);

  logic [WIDTH-1:0] cnt, cnt_next;
  logic [WIDTH-1:0] div_q, div_next;
  logic [WIDTH-1:0] div_p, div_p_next;
  logic             mode_q, mode_next;
  logic             mode_p, mode_p_next;
  logic             pend_q, pend_next;
  logic             tick_q, tick_next;
  logic             err_q, err_next;

  logic             wrap;
  logic             load_ok;
  logic [WIDTH:0]   half;

  assign wrap    = en && (cnt == (div_q - ONE));
  assign load_ok = load && (div_in != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      div_q  <= DEF_DIV;
      mode_q <= 1'b0;
      div_p  <= DEF_DIV;
      mode_p <= 1'b0;
      pend_q <= 1'b0;
      tick_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      div_q  <= div_next;
      mode_q <= mode_next;
      div_p  <= div_p_next;
      mode_p <= mode_p_next;
      pend_q <= pend_next;
      tick_q <= tick_next;
      err_q  <= err_next;
    end
  end

  always_comb begin
    cnt_next    = cnt;
    div_next    = div_q;
    mode_next   = mode_q;
    div_p_next  = div_p;
    mode_p_next = mode_p;
    pend_next   = pend_q;
    tick_next   = wrap;
    err_next    = load && (div_in == '0);

    if (en) begin
      cnt_next = wrap ? '0 : cnt + ONE;
    end

    // A load landing on the wrap edge bypasses the pending slot entirely.
    if (load_ok) begin
      if (wrap) begin
        div_next  = div_in;
        mode_next = mode_in;
        pend_next = 1'b0;
      end else begin
        div_p_next  = div_in;
        mode_p_next = mode_in;
        pend_next   = 1'b1;
      end
    end else if (wrap && pend_q) begin
      div_next  = div_p;
      mode_next = mode_p;
      pend_next = 1'b0;
    end
  end

  // High-phase length computed one bit wider so the all-ones divisor cannot overflow.
  assign half    = ({1'b0, div_q} + ONE_X) >> 1;
  assign y       = mode_q ? ({1'b0, cnt} < half) : (cnt == '0);
  assign tick    = tick_q;
  assign err     = err_q;
  assign pending = pend_q;
  assign div_o   = div_q;

endmodule

// File: tb/tb_divideby_n_fsm.sv
// Directed and randomized checks of divideby_n_fsm against a period-level
// reference model; every cycle's outputs are compared with the model.
module tb_divideby_n_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] div_in = 8'd0;
  logic       mode_in = 1'b0;
  logic       y, tick, err, pending;
  logic [7:0] div_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: position within the current period plus settings.
  int m_phase, m_div, m_mode, m_pend, m_pdiv, m_pmode, m_tick, m_err;

  divideby_n_fsm #(.WIDTH(8), .DEFAULT_DIV(3)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .div_in(div_in),
    .mode_in(mode_in), .y(y), .tick(tick), .err(err), .pending(pending),
    .div_o(div_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_y();
    if (m_mode != 0) return (2 * m_phase < m_div) ? 1 : 0;
    return (m_phase == 0) ? 1 : 0;
  endfunction

  task automatic model_edge(input int r, input int e, input int l, input int d, input int m);
    int last;
    if (r != 0) begin
      m_phase = 0; m_div = 3; m_mode = 0; m_pend = 0; m_tick = 0; m_err = 0;
      return;
    end
    last   = (e != 0) && (m_phase + 1 == m_div);
    m_err  = (l != 0) && (d == 0);
    m_tick = last;
    if (e != 0) m_phase = last ? 0 : m_phase + 1;
    if (l != 0 && d != 0) begin
      if (last) begin m_div = d; m_mode = m; m_pend = 0; end
      else begin m_pdiv = d; m_pmode = m; m_pend = 1; end
    end else if (last && m_pend != 0) begin
      m_div = m_pdiv; m_mode = m_pmode; m_pend = 0;
    end
  endtask

  task automatic check_all();
    check("y", int'(y), model_y());
    check("tick", int'(tick), m_tick);
    check("err", int'(err), m_err);
    check("pending", int'(pending), m_pend);
    check("div_o", int'(div_o), m_div);
  endtask

  task automatic step(input int r, input int e, input int l, input int d, input int m);
    reset = r[0]; en = e[0]; load = l[0]; div_in = d[7:0]; mode_in = m[0];
    @(posedge clk);
    model_edge(r, e, l, d, m);
    #1;
    check_all();
    reset = 1'b0; load = 1'b0;
  endtask

  task automatic run_to_phase(input int p);
    int n = 0;
    while (m_phase != p && n < 300) begin
      step(0, 1, 0, 0, 0);
      n++;
    end
    check("phase_reached", int'(m_phase == p), 1);
  endtask

  initial begin
    int hi, ysave, d, bad4;
    m_pdiv = 3; m_pmode = 0;

    // Reset then nine enabled observations: y=1,0,0 repeating, tick at 3 and 6.
    step(1, 0, 0, 0, 0);
    check("rst_y", int'(y), 1);
    check("rst_div_o", int'(div_o), 3);
    for (int k = 1; k < 9; k++) begin
      step(0, 1, 0, 0, 0);
      check("seq_y", int'(y), (k % 3 == 0) ? 1 : 0);
      check("seq_tick", int'(tick), (k == 3 || k == 6) ? 1 : 0);
    end

    // Load 5/square while cnt==1.
    run_to_phase(1);
    step(0, 1, 1, 5, 1);
    check("pend_after_load", int'(pending), 1);
    check("div_o_before_wrap", int'(div_o), 3);
    run_to_phase(0);
    check("div_o_after_wrap", int'(div_o), 5);
    for (int k = 1; k <= 5; k++) begin
      step(0, 1, 0, 0, 0);
      check("sq5_y", int'(y), ((k % 5) < 3) ? 1 : 0);
    end

    // Rejected load of zero.
    step(0, 1, 1, 0, 1);
    check("err_pulse", int'(err), 1);
    step(0, 1, 0, 0, 0);
    check("err_clear", int'(err), 0);
    check("div_o_kept", int'(div_o), 5);

    // Two loads in one period; only the last one ever applies.
    run_to_phase(0);
    bad4 = 0;
    step(0, 1, 1, 4, 0);
    step(0, 1, 1, 2, 0);
    for (int k = 0; k < 12; k++) begin
      step(0, 1, 0, 0, 0);
      if (div_o == 8'd4) bad4++;
    end
    check("never_div4", bad4, 0);
    check("div_o_2", int'(div_o), 2);

    // Load landing on the wrap edge applies immediately.
    run_to_phase(1);
    step(0, 1, 1, 3, 0);
    check("wrap_load_div", int'(div_o), 3);
    check("wrap_load_pend", int'(pending), 0);

    // Enable low for 4 cycles mid-period.
    run_to_phase(1);
    ysave = int'(y);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 0);
      check("hold_y", int'(y), ysave);
      check("hold_tick", int'(tick), 0);
    end
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    check("resume_tick", int'(tick), 1);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 7));
      step(($urandom_range(0, 99) == 0) ? 1 : 0,
           ($urandom_range(0, 3) != 0) ? 1 : 0,
           ($urandom_range(0, 7) == 0) ? 1 : 0,
           d, int'($urandom_range(0, 1)));
    end

    // Divide by 1 in pulse mode: y and tick stay high.
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0);
    step(0, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 0, 0);
      check("n1_y", int'(y), 1);
      check("n1_tick", int'(tick), 1);
    end

    // Maximum divisor, square mode: 128 high, 127 low.
    step(0, 1, 1, 255, 1);
    check("div255_applied", int'(div_o), 255);
    hi = int'(y);
    for (int k = 1; k < 255; k++) begin
      step(0, 1, 0, 0, 0);
      hi += int'(y);
    end
    check("div255_high_cycles", hi, 128);
    for (int k = 0; k < 40; k++) step(0, 1, 0, 0, 0);

    // Reset mid-period beats a coinciding load.
    step(1, 1, 1, 9, 1);
    check("rst_load_div", int'(div_o), 3);
    check("rst_load_pend", int'(pending), 0);
    check("rst_load_y", int'(y), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
